n64_vinfo_ext_gen: RTL and testbench

Parametrised successor to the video-info extractor. It sits after the sync-sampling stage and before the de-mux and the scanline/deblur logic. It derives the data-counter phase, 240p/480i, NTSC/PAL and the current field, and measures lines per field. Mode decisions use a line-count threshold with multi-frame hysteresis instead of a single-frame guess. It also adds a valid flag and a mode-change strobe.

---
 rtl/n64_vinfo_ext_gen_if.sv | 25 ++
 rtl/n64_vinfo_ext_gen.sv | 135 +++++++++++++
 tb/tb_n64_vinfo_ext_gen.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/n64_vinfo_ext_gen_if.sv
// Sync-word inputs and video-info outputs between the sync sampler and the
// info extractor.
interface n64_vinfo_ext_gen_if #(
    parameter int DCNT_W = 2,
    parameter int LINE_W = 10
);
    logic              nDSYNC;
    logic [3:0]        Sync_pre;
    logic [3:0]        Sync_cur;
    logic [DCNT_W+1:0] vinfo_o;
    logic              field_o;
    logic [LINE_W-1:0] lines_o;
    logic              vinfo_valid_o;
    logic              mode_chg_o;

    modport master (
        output nDSYNC, Sync_pre, Sync_cur,
        input  vinfo_o, field_o, lines_o, vinfo_valid_o, mode_chg_o
    );

    modport slave (
        input  nDSYNC, Sync_pre, Sync_cur,
        output vinfo_o, field_o, lines_o, vinfo_valid_o, mode_chg_o
    );
endinterface

// File: rtl/n64_vinfo_ext_gen.sv
// Video-info extractor: data-counter phase, field ID, lines per field and
// hysteresis-filtered 240p/480i and NTSC/PAL decisions.
module n64_vinfo_ext_gen #(
    parameter int DCNT_W      = 2,
    parameter int LINE_W      = 10,
    parameter int PAL_THRESH  = 288,
    parameter int LOCK_FRAMES = 3
) (
    input logic                nCLK,
    input logic                RST,
    n64_vinfo_ext_gen_if.slave vif
);
    localparam logic [LINE_W-1:0] LINE_MAX = {LINE_W{1'b1}};
    localparam logic [3:0]        LOCK     = 4'(LOCK_FRAMES);

    logic [DCNT_W-1:0] data_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [LINE_W-1:0] lines_r;
    logic              n64_480i;
    logic              vmode;
    logic              field_r;
    logic              field_seen;
    logic              armed;
    logic              valid_r;
    logic              mode_chg_r;
    logic [3:0]        cnt_480i;
    logic [3:0]        cnt_vmode;

    logic vs_pos, vs_neg, hs_pos, hs_neg;
    logic line_sat;
    logic cand_480i, cand_vmode;
    logic eval_480i, eval_vmode;
    logic n64_480i_nx, vmode_nx;
    logic [3:0] cnt_480i_nx, cnt_vmode_nx;
    logic commit_480i, commit_vmode;
    logic valid_nx;
    logic sync_unused;

    // Edges only mean anything on control words.
    assign vs_pos = ~vif.nDSYNC & ~vif.Sync_pre[3] &  vif.Sync_cur[3];
    assign vs_neg = ~vif.nDSYNC &  vif.Sync_pre[3] & ~vif.Sync_cur[3];
    assign hs_pos = ~vif.nDSYNC & ~vif.Sync_pre[1] &  vif.Sync_cur[1];
    assign hs_neg = ~vif.nDSYNC &  vif.Sync_pre[1] & ~vif.Sync_cur[1];
    assign sync_unused = ^{vif.Sync_pre[2], vif.Sync_pre[0],
                           vif.Sync_cur[2], vif.Sync_cur[0]};

    assign line_sat   = (line_cnt == LINE_MAX);
    assign cand_vmode = line_sat || (32'(line_cnt) > PAL_THRESH);
    assign cand_480i  = (hs_neg != field_r);
    assign eval_480i  = vs_neg & field_seen;
    assign eval_vmode = vs_pos & armed;
    assign valid_nx   = valid_r | eval_vmode;

    always_comb begin
        n64_480i_nx = n64_480i;
        cnt_480i_nx = cnt_480i;
        commit_480i = 1'b0;
        if (eval_480i) begin
            if (cand_480i == n64_480i) begin
                cnt_480i_nx = 4'd0;
            end else if (cnt_480i + 4'd1 >= LOCK) begin
                n64_480i_nx = cand_480i;
                cnt_480i_nx = 4'd0;
                commit_480i = 1'b1;
            end else begin
                cnt_480i_nx = cnt_480i + 4'd1;
            end
        end
    end

    always_comb begin
        vmode_nx     = vmode;
        cnt_vmode_nx = cnt_vmode;
        commit_vmode = 1'b0;
        if (eval_vmode) begin
            if (cand_vmode == vmode) begin
                cnt_vmode_nx = 4'd0;
            end else if (cnt_vmode + 4'd1 >= LOCK) begin
                vmode_nx     = cand_vmode;
                cnt_vmode_nx = 4'd0;
                commit_vmode = 1'b1;
            end else begin
                cnt_vmode_nx = cnt_vmode + 4'd1;
            end
        end
    end

    always_ff @(negedge nCLK) begin
        if (RST) begin
            data_cnt   <= '0;
            line_cnt   <= '0;
            lines_r    <= '0;
            n64_480i   <= 1'b1;
            vmode      <= 1'b0;
            field_r    <= 1'b0;
            field_seen <= 1'b0;
            armed      <= 1'b0;
            valid_r    <= 1'b0;
            mode_chg_r <= 1'b0;
            cnt_480i   <= '0;
            cnt_vmode  <= '0;
        end else begin
            data_cnt <= vif.nDSYNC ? data_cnt + 1'b1 : DCNT_W'(1);

            // A vsync rising edge swallows any hsync edge in the same word.
            if (vs_pos) begin
                armed    <= 1'b1;
                line_cnt <= '0;
                if (armed) begin
                    lines_r <= line_cnt;
                    valid_r <= 1'b1;
                end
            end else if (hs_pos && !line_sat) begin
                line_cnt <= line_cnt + 1'b1;
            end

            if (vs_neg) begin
                field_r    <= hs_neg;
                field_seen <= 1'b1;
            end

            n64_480i   <= n64_480i_nx;
            cnt_480i   <= cnt_480i_nx;
            vmode      <= vmode_nx;
            cnt_vmode  <= cnt_vmode_nx;
            mode_chg_r <= (commit_480i | commit_vmode) & valid_nx;
        end
    end

    assign vif.vinfo_o       = {data_cnt, n64_480i, vmode};
    assign vif.field_o       = field_r;
    assign vif.lines_o       = lines_r;
    assign vif.vinfo_valid_o = valid_r;
    assign vif.mode_chg_o    = mode_chg_r;
endmodule

// File: tb/tb_n64_vinfo_ext_gen.sv
// Randomized field-level bench for n64_vinfo_ext_gen; a 10-bit and an 8-bit
// line-counter instance see identical sync streams.
module tb_n64_vinfo_ext_gen;
    localparam int DCNT_W      = 2;
    localparam int LINE_W      = 10;
    localparam int LINE_W8     = 8;
    localparam int PAL_THRESH  = 288;
    localparam int LOCK_FRAMES = 3;

    logic nCLK = 1'b0;
    logic RST  = 1'b1;
    always #5 nCLK = ~nCLK;

    n64_vinfo_ext_gen_if #(.DCNT_W(DCNT_W), .LINE_W(LINE_W))  vif ();
    n64_vinfo_ext_gen_if #(.DCNT_W(DCNT_W), .LINE_W(LINE_W8)) vif8 ();

    n64_vinfo_ext_gen #(.DCNT_W(DCNT_W), .LINE_W(LINE_W), .PAL_THRESH(PAL_THRESH),
                        .LOCK_FRAMES(LOCK_FRAMES))
        dut (.nCLK(nCLK), .RST(RST), .vif(vif));
    n64_vinfo_ext_gen #(.DCNT_W(DCNT_W), .LINE_W(LINE_W8), .PAL_THRESH(PAL_THRESH),
                        .LOCK_FRAMES(LOCK_FRAMES))
        dut8 (.nCLK(nCLK), .RST(RST), .vif(vif8));

    // Per-field view of the expected video info.
    typedef struct {
        bit first_done;
        bit armed;
        bit valid;
        bit fld;
        bit i480;
        bit vm;
        int c480;
        int cvm;
        int lines;
        int lmax;
    } ms_t;

    ms_t m10, m8;
    int  dc;
    bit  ec10, ec8;
    int  pend_l;
    int  n_total = 0;
    int  n_pass  = 0;
    int  n_fail  = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic ms_t m_reset(int lmax);
        ms_t s;
        s.first_done = 0; s.armed = 0; s.valid = 0; s.fld = 0;
        s.i480 = 1; s.vm = 0; s.c480 = 0; s.cvm = 0; s.lines = 0; s.lmax = lmax;
        return s;
    endfunction

    function automatic void hyst(inout bit val, inout int cnt, input bit cand, output bit commit);
        commit = 0;
        if (cand == val) cnt = 0;
        else begin
            cnt++;
            if (cnt == LOCK_FRAMES) begin
                val = cand;
                cnt = 0;
                commit = 1;
            end
        end
    endfunction

    function automatic ms_t m_vneg(ms_t s, bit p, output bit chg);
        bit c;
        chg = 0;
        if (s.first_done) begin
            hyst(s.i480, s.c480, p != s.fld, c);
            chg = c && s.valid;
        end
        s.fld = p;
        s.first_done = 1;
        return s;
    endfunction

    function automatic ms_t m_vpos(ms_t s, int l, output bit chg);
        bit c;
        chg = 0;
        if (!s.armed) s.armed = 1;
        else begin
            s.lines = (l > s.lmax) ? s.lmax : l;
            s.valid = 1;
            hyst(s.vm, s.cvm, (s.lines == s.lmax) || (s.lines > PAL_THRESH), c);
            chg = c;
        end
        return s;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic drive(bit nd, logic [3:0] pre, logic [3:0] cur);
        vif.nDSYNC  = nd; vif.Sync_pre  = pre; vif.Sync_cur  = cur;
        vif8.nDSYNC = nd; vif8.Sync_pre = pre; vif8.Sync_cur = cur;
        @(negedge nCLK);
        dc = nd ? (dc + 1) % 4 : 1;
        @(posedge nCLK);
        check("data_cnt", 32'(vif.vinfo_o[3:2]), dc);
        check("data_cnt8", 32'(vif8.vinfo_o[3:2]), dc);
        check("mode_chg", 32'(vif.mode_chg_o), 32'(ec10));
        check("mode_chg8", 32'(vif8.mode_chg_o), 32'(ec8));
        ec10 = 0;
        ec8  = 0;
    endtask

    // Data words carry arbitrary sync vectors that must be ignored.
    task automatic fill(int n);
        repeat (n) drive(1'b1, 4'($urandom), 4'($urandom));
    endtask

    task automatic hsync_word();
        drive(1'b0, {1'b1, rb(), 1'b0, rb()}, {1'b1, rb(), 1'b1, rb()});
    endtask

    task automatic do_reset();
        RST = 1'b1;
        vif.nDSYNC  = 1'b1; vif.Sync_pre  = 4'hF; vif.Sync_cur  = 4'hF;
        vif8.nDSYNC = 1'b1; vif8.Sync_pre = 4'hF; vif8.Sync_cur = 4'hF;
        @(negedge nCLK);
        dc = 0;
        m10 = m_reset((1 << LINE_W) - 1);
        m8  = m_reset((1 << LINE_W8) - 1);
        ec10 = 0; ec8 = 0;
        @(posedge nCLK);
        RST = 1'b0;
        check("rst_vinfo", 32'(vif.vinfo_o), 32'b0010);
        check("rst_field", 32'(vif.field_o), 0);
        check("rst_lines", 32'(vif.lines_o), 0);
        check("rst_valid", 32'(vif.vinfo_valid_o), 0);
        check("rst_chg", 32'(vif.mode_chg_o), 0);
        check("rst_vinfo8", 32'(vif8.vinfo_o), 32'b0010);
        check("rst_lines8", 32'(vif8.lines_o), 0);
        check("rst_valid8", 32'(vif8.vinfo_valid_o), 0);
    endtask

    // One field: vsync fall (field ID), vsync rise (latches previous count), l lines.
    task automatic gen_field(int l, bit p, bit coinc);
        bit c;
        m10 = m_vneg(m10, p, c); ec10 = c;
        m8  = m_vneg(m8, p, c);  ec8  = c;
        drive(1'b0, {1'b1, rb(), 1'b1, rb()}, {1'b0, rb(), ~p, rb()});
        check("field", 32'(vif.field_o), 32'(m10.fld));
        check("n64_480i", 32'(vif.vinfo_o[1]), 32'(m10.i480));
        check("n64_480i8", 32'(vif8.vinfo_o[1]), 32'(m8.i480));
        fill($urandom_range(0, 2));
        m10 = m_vpos(m10, pend_l, c); ec10 = c;
        m8  = m_vpos(m8, pend_l, c);  ec8  = c;
        drive(1'b0, {1'b0, rb(), ~coinc, rb()}, {1'b1, rb(), 1'b1, rb()});
        check("lines", 32'(vif.lines_o), m10.lines);
        check("lines8", 32'(vif8.lines_o), m8.lines);
        check("valid", 32'(vif.vinfo_valid_o), 32'(m10.valid));
        check("valid8", 32'(vif8.vinfo_valid_o), 32'(m8.valid));
        check("vmode", 32'(vif.vinfo_o[0]), 32'(m10.vm));
        check("vmode8", 32'(vif8.vinfo_o[0]), 32'(m8.vm));
        for (int i = 0; i < l; i++) begin
            hsync_word();
            if ($urandom_range(0, 3) == 0) fill(1);
        end
        pend_l = l;
    endtask

    initial begin
        int seq[5];
        seq = '{1, 2, 3, 0, 1};
        pend_l = 0;
        do_reset();

        // NTSC 240p, one field with coincident vsync/hsync rise.
        for (int f = 0; f < 6; f++) gen_field(263, 1'b0, f == 3);
        check("ntsc_lines", 32'(vif.lines_o), 263);
        check("ntsc_480i", 32'(vif.vinfo_o[1]), 0);
        check("ntsc_vmode", 32'(vif.vinfo_o[0]), 0);
        check("ntsc_lines8", 32'(vif8.lines_o), 255);

        // Single long field must not flip vmode.
        gen_field(313, 1'b0, 1'b0);
        gen_field(263, 1'b0, 1'b0);
        gen_field(263, 1'b0, 1'b0);
        check("glitch_vmode", 32'(vif.vinfo_o[0]), 0);

        // PAL 480i from reset.
        do_reset();
        for (int f = 0; f < 6; f++) gen_field((f % 2) ? 313 : 312, 1'(f % 2 == 0), 1'b0);
        check("pal_vmode", 32'(vif.vinfo_o[0]), 1);
        check("pal_480i", 32'(vif.vinfo_o[1]), 1);

        for (int f = 0; f < 12; f++)
            gen_field($urandom_range(250, 330), rb(), rb());

        for (int f = 0; f < 5; f++) gen_field(300, 1'b0, 1'b0);
        check("sat_lines8", 32'(vif8.lines_o), 255);
        check("sat_lines", 32'(vif.lines_o), 300);
        check("sat_vmode8", 32'(vif8.vinfo_o[0]), 1);
        check("sat_vmode", 32'(vif.vinfo_o[0]), 1);

        // Reset in the middle of a field.
        gen_field(263, 1'b0, 1'b0);
        repeat (50) hsync_word();
        do_reset();
        gen_field(263, 1'b0, 1'b0);
        check("rearm_valid", 32'(vif.vinfo_valid_o), 0);
        gen_field(263, 1'b0, 1'b0);
        check("revalid", 32'(vif.vinfo_valid_o), 1);
        gen_field(263, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            drive(i != 0, 4'hF, 4'hF);
            check("dcnt_seq", 32'(vif.vinfo_o[3:2]), seq[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
